// File: rtl/ahbl_i2s_tx.sv
// AHB-Lite slave I2S master transmitter: 32-bit sample FIFO, SCK/WS generation, MSB-first SD.
// Optional macro I2S_TX_IRQ_EN adds the irq output and the THRESH register at 0x10.
module ahbl_i2s_tx #(
    parameter int FIFO_AW = 4,
    parameter int PRE_W   = 8
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HSEL,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        SCK,
    output logic        WS,
    output logic        SD,
`ifdef I2S_TX_IRQ_EN
    output logic        irq,
`endif
    output logic        empty
);
    logic [7:0]         r_addr;
    logic               r_trans, r_write, r_sel;
    logic               r_en, r_sck, r_ws, r_sd, r_und, r_ovf;
    logic [PRE_W-1:0]   r_presc, r_cnt;
    logic [5:0]         r_pos;
    logic [31:0]        r_sh;
    logic [31:0]        r_mem [2**FIFO_AW];
    logic [FIFO_AW:0]   r_wp, r_rp;

    logic               w_wr, w_wr_ctrl, w_wr_stat, w_wr_data, w_wr_presc;
    logic [FIFO_AW:0]   w_level;
    logic               w_empty, w_full, w_flush, w_push, w_pop, w_pop_req;
    logic               w_en_rise, w_en_off, w_tick, w_fall, w_rise, w_slot0;
    logic [5:0]         w_pos_nxt;
    logic [31:0]        w_word;
    logic               w_unused;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_addr  <= '0;
            r_trans <= 1'b0;
            r_write <= 1'b0;
            r_sel   <= 1'b0;
        end else if (HREADY) begin
            r_addr  <= HADDR[7:0];
            r_trans <= HTRANS[1];
            r_write <= HWRITE;
            r_sel   <= HSEL;
        end
    end

    assign w_wr       = r_sel & r_trans & r_write;
    assign w_wr_ctrl  = w_wr & (r_addr == 8'h00);
    assign w_wr_stat  = w_wr & (r_addr == 8'h04);
    assign w_wr_data  = w_wr & (r_addr == 8'h08);
    assign w_wr_presc = w_wr & (r_addr == 8'h0C);

    assign w_level = r_wp - r_rp;
    assign w_empty = (w_level == '0);
    assign w_full  = w_level[FIFO_AW];
    assign w_flush = w_wr_ctrl & HWDATA[1];

    assign w_en_rise = w_wr_ctrl & HWDATA[0] & ~r_en;
    assign w_en_off  = w_wr_ctrl & ~HWDATA[0];
    assign w_tick    = r_en & (r_cnt == '0);
    // Enabling fires the left-p0 falling edge immediately; SCK is already low then.
    assign w_fall    = w_en_rise | (w_tick & r_sck & ~w_en_off);
    assign w_rise    = w_tick & ~r_sck;
    assign w_pos_nxt = w_en_rise ? 6'd0 : r_pos + 6'd1;
    assign w_slot0   = (w_pos_nxt[4:0] == 5'd0);

    assign w_pop_req = w_fall & w_slot0;
    assign w_pop     = w_pop_req & ~w_empty;
    assign w_push    = w_wr_data & (~w_full | w_pop) & ~w_flush;
    assign w_word    = w_empty ? '0 : r_mem[r_rp[FIFO_AW-1:0]];

    always_ff @(posedge HCLK) begin
        if (w_push)
            r_mem[r_wp[FIFO_AW-1:0]] <= HWDATA;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_und   <= 1'b0;
            r_ovf   <= 1'b0;
            r_presc <= PRE_W'(3);
        end else begin
            if (w_flush) begin
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                r_wp <= r_wp + {{FIFO_AW{1'b0}}, w_push};
                r_rp <= r_rp + {{FIFO_AW{1'b0}}, w_pop};
            end
            r_und <= (w_pop_req & w_empty) | (r_und & ~(w_wr_stat & HWDATA[2]));
            r_ovf <= (w_wr_data & w_full & ~w_pop & ~w_flush) | (r_ovf & ~(w_wr_stat & HWDATA[3]));
            if (w_wr_presc)
                r_presc <= HWDATA[PRE_W-1:0];
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_en  <= 1'b0;
            r_cnt <= '0;
            r_pos <= '0;
            r_sck <= 1'b0;
            r_ws  <= 1'b0;
            r_sd  <= 1'b0;
            r_sh  <= '0;
        end else if (w_en_off) begin
            r_en  <= 1'b0;
            r_cnt <= '0;
            r_pos <= '0;
            r_sck <= 1'b0;
            r_ws  <= 1'b0;
            r_sd  <= 1'b0;
        end else begin
            if (w_en_rise)
                r_en <= 1'b1;
            if (w_fall) begin
                r_sck <= 1'b0;
                r_cnt <= r_presc;
                r_pos <= w_pos_nxt;
                // WS leads the slot MSB by one bit: high over frame positions 31..62
                r_ws  <= (w_pos_nxt >= 6'd31) && (w_pos_nxt <= 6'd62);
                if (w_slot0) begin
                    r_sh <= w_word;
                    r_sd <= w_word[31];
                end else begin
                    r_sh <= {r_sh[30:0], 1'b0};
                    r_sd <= r_sh[30];
                end
            end else if (w_rise) begin
                r_sck <= 1'b1;
                r_cnt <= r_presc;
            end else if (r_en) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

`ifdef I2S_TX_IRQ_EN
    logic [FIFO_AW:0] r_thresh;
    logic             r_irq;
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_thresh <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr & (r_addr == 8'h10))
                r_thresh <= HWDATA[FIFO_AW:0];
            r_irq <= (r_en & (w_level <= r_thresh)) | r_und;
        end
    end
    assign irq = r_irq;
`endif

    always_comb begin
        HRDATA = 32'hBADDBEEF;
        case (r_addr)
            8'h00: HRDATA = {31'b0, r_en};
            8'h04: begin
                HRDATA = '0;
                HRDATA[0] = w_empty;
                HRDATA[1] = w_full;
                HRDATA[2] = r_und;
                HRDATA[3] = r_ovf;
                HRDATA[8 +: FIFO_AW+1] = w_level;
            end
            8'h08: HRDATA = '0;
            8'h0C: HRDATA = {{(32-PRE_W){1'b0}}, r_presc};
`ifdef I2S_TX_IRQ_EN
            8'h10: HRDATA = {{(31-FIFO_AW){1'b0}}, r_thresh};
`endif
            default: HRDATA = 32'hBADDBEEF;
        endcase
    end

    assign HREADYOUT = 1'b1;
    assign SCK       = r_sck;
    assign WS        = r_ws;
    assign SD        = r_sd;
    assign empty     = w_empty;
    assign w_unused  = ^{HSIZE, HADDR[31:8], HTRANS[0], r_sh[31]};
endmodule
